// File: rtl/dma_csr_tl_if.sv
// TileLink-UL CSR port (A request / D response channels) for the DMA CSR block.
interface dma_csr_tl_if #(
    parameter int TL_AW = 32
);
    logic [2:0]       csr_a_opcode;
    logic [2:0]       csr_a_param;
    logic [3:0]       csr_a_size;
    logic [TL_AW-1:0] csr_a_address;
    logic [3:0]       csr_a_mask;
    logic [31:0]      csr_a_data;
    logic             csr_a_corrupt;
    logic             csr_a_valid;
    logic             csr_a_ready;

    logic [2:0]       csr_d_opcode;
    logic [1:0]       csr_d_param;
    logic [3:0]       csr_d_size;
    logic             csr_d_denied;
    logic [31:0]      csr_d_data;
    logic             csr_d_corrupt;
    logic             csr_d_valid;
    logic             csr_d_ready;

    modport master (
        output csr_a_opcode, csr_a_param, csr_a_size, csr_a_address, csr_a_mask,
               csr_a_data, csr_a_corrupt, csr_a_valid, csr_d_ready,
        input  csr_a_ready, csr_d_opcode, csr_d_param, csr_d_size, csr_d_denied,
               csr_d_data, csr_d_corrupt, csr_d_valid
    );
    modport slave (
        input  csr_a_opcode, csr_a_param, csr_a_size, csr_a_address, csr_a_mask,
               csr_a_data, csr_a_corrupt, csr_a_valid, csr_d_ready,
        output csr_a_ready, csr_d_opcode, csr_d_param, csr_d_size, csr_d_denied,
               csr_d_data, csr_d_corrupt, csr_d_valid
    );
endinterface

// File: rtl/dma_csr_tl.sv
// DMA control/status registers behind a TileLink-UL slave port.
// Interrupt logic is built only when DMA_CSR_IRQ_EN is defined.
module dma_csr_tl #(
    parameter int TL_AW = 32
) (
    input  logic             dmac_clock_i,
    input  logic             dmac_reset_ni,
    dma_csr_tl_if.slave      csr,
    output logic             dmac_tx_o,
    output logic [TL_AW-1:0] dmac_source_address_o,
    output logic [TL_AW-1:0] dmac_dest_address_o,
    output logic [TL_AW-1:0] dmac_bytes_tx_o,
    output logic             dmac_stationary_rd_o,
    output logic             dmac_stationary_wr_o,
    input  logic             dmac_busy_i,
    input  logic             dmac_done_i,
    input  logic             dmac_err_i,
    output logic             dmac_irq_o
);
    localparam logic [2:0] OP_PUT_FULL = 3'd0, OP_PUT_PART = 3'd1, OP_GET = 3'd4;
    localparam logic [2:0] D_ACK = 3'd0, D_ACK_DATA = 3'd1;
    localparam logic [2:0] R_CTRL = 3'd0, R_STATUS = 3'd1, R_SRC = 3'd2, R_DST = 3'd3, R_LEN = 3'd4;

    logic [TL_AW-1:0] src_q, dst_q, len_q;
    logic             stat_rd_q, stat_wr_q, done_q, err_q, busy_q, tx_q, irq_en;
    logic             d_valid_q, d_denied_q;
    logic [2:0]       d_opcode_q;
    logic [3:0]       d_size_q;
    logic [31:0]      d_data_q;

    logic [2:0]  sel;
    logic        a_fire, is_get, is_put, denied, wr, start, complete;
    logic        w1c_done, w1c_err, done_d, err_d;
    logic [31:0] rdata;

    function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    assign sel              = csr.csr_a_address[4:2];
    assign csr.csr_a_ready  = dmac_reset_ni & (~d_valid_q | csr.csr_d_ready);
    assign a_fire           = csr.csr_a_valid & csr.csr_a_ready;
    assign is_get           = csr.csr_a_opcode == OP_GET;
    assign is_put           = csr.csr_a_opcode == OP_PUT_FULL || csr.csr_a_opcode == OP_PUT_PART;

    // Core-facing registers are frozen while a transfer runs; STATUS stays writable for W1C.
    assign denied = ~(is_get | is_put) | (csr.csr_a_size > 4'd2) | (sel > R_LEN)
                  | (is_put & (sel != R_STATUS) & dmac_busy_i);
    assign wr       = a_fire & is_put & ~denied;
    assign start    = wr & (sel == R_CTRL) & csr.csr_a_mask[0] & csr.csr_a_data[0] & ~dmac_busy_i;
    assign w1c_done = wr & (sel == R_STATUS) & csr.csr_a_mask[0] & csr.csr_a_data[1];
    assign w1c_err  = wr & (sel == R_STATUS) & csr.csr_a_mask[0] & csr.csr_a_data[2];
    // A START issued before busy rises cannot fire this: it needs an observed busy=1.
    assign complete = busy_q & ~dmac_busy_i;

    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (start || w1c_done) done_d = 1'b0;
        if (start || w1c_err)  err_d  = 1'b0;
        if (complete) begin
            done_d = 1'b1;
            err_d  = dmac_err_i;
        end
    end

    always_comb begin
        rdata = '0;
        if (is_get && !denied) begin
            case (sel)
                R_CTRL:   rdata = {28'd0, irq_en, stat_wr_q, stat_rd_q, 1'b0};
                R_STATUS: rdata = {29'd0, err_q, done_q, dmac_busy_i};
                R_SRC:    rdata = 32'(src_q);
                R_DST:    rdata = 32'(dst_q);
                R_LEN:    rdata = 32'(len_q);
                default:  rdata = '0;
            endcase
        end
    end

    always_ff @(posedge dmac_clock_i or negedge dmac_reset_ni) begin
        if (!dmac_reset_ni) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            stat_rd_q <= 1'b0;
            stat_wr_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            tx_q      <= 1'b0;
        end else begin
            tx_q   <= start;
            busy_q <= dmac_busy_i;
            done_q <= done_d;
            err_q  <= err_d;
            if (wr && sel == R_SRC) src_q <= TL_AW'(bmerge(32'(src_q), csr.csr_a_data, csr.csr_a_mask));
            if (wr && sel == R_DST) dst_q <= TL_AW'(bmerge(32'(dst_q), csr.csr_a_data, csr.csr_a_mask));
            if (wr && sel == R_LEN) len_q <= TL_AW'(bmerge(32'(len_q), csr.csr_a_data, csr.csr_a_mask));
            if (wr && sel == R_CTRL && csr.csr_a_mask[0]) begin
                stat_rd_q <= csr.csr_a_data[1];
                stat_wr_q <= csr.csr_a_data[2];
            end
        end
    end

    always_ff @(posedge dmac_clock_i or negedge dmac_reset_ni) begin
        if (!dmac_reset_ni) begin
            d_valid_q  <= 1'b0;
            d_denied_q <= 1'b0;
            d_opcode_q <= D_ACK;
            d_size_q   <= '0;
            d_data_q   <= '0;
        end else if (a_fire) begin
            d_valid_q  <= 1'b1;
            d_denied_q <= denied;
            d_opcode_q <= is_get ? D_ACK_DATA : D_ACK;
            d_size_q   <= csr.csr_a_size;
            d_data_q   <= rdata;
        end else if (csr.csr_d_ready) begin
            d_valid_q  <= 1'b0;
        end
    end

`ifdef DMA_CSR_IRQ_EN
    logic irq_en_q, irq_q;
    assign irq_en = irq_en_q;
    always_ff @(posedge dmac_clock_i or negedge dmac_reset_ni) begin
        if (!dmac_reset_ni) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && sel == R_CTRL && csr.csr_a_mask[0]) irq_en_q <= csr.csr_a_data[3];
            irq_q <= irq_en_q & (done_q | err_q);
        end
    end
    assign dmac_irq_o = irq_q;
`else
    assign irq_en     = 1'b0;
    assign dmac_irq_o = 1'b0;
`endif

    assign csr.csr_d_valid   = d_valid_q;
    assign csr.csr_d_opcode  = d_opcode_q;
    assign csr.csr_d_param   = 2'd0;
    assign csr.csr_d_size    = d_size_q;
    assign csr.csr_d_denied  = d_denied_q;
    assign csr.csr_d_data    = d_data_q;
    assign csr.csr_d_corrupt = 1'b0;

    assign dmac_tx_o             = tx_q;
    assign dmac_source_address_o = src_q;
    assign dmac_dest_address_o   = dst_q;
    assign dmac_bytes_tx_o       = len_q;
    assign dmac_stationary_rd_o  = stat_rd_q;
    assign dmac_stationary_wr_o  = stat_wr_q;

    logic unused_ok;
    assign unused_ok = ^{dmac_done_i, csr.csr_a_param, csr.csr_a_corrupt, csr.csr_a_address};
endmodule

// File: tb/tb_dma_csr_tl.sv
// Directed bench for dma_csr_tl: register access, START, completion, denial, irq, backpressure.
module tb_dma_csr_tl;
    localparam int TL_AW = 32;

    logic             dmac_clock_i = 1'b0;
    logic             dmac_reset_ni = 1'b0;
    logic             dmac_tx_o, dmac_stationary_rd_o, dmac_stationary_wr_o, dmac_irq_o;
    logic [TL_AW-1:0] dmac_source_address_o, dmac_dest_address_o, dmac_bytes_tx_o;
    logic             dmac_busy_i = 1'b0, dmac_done_i = 1'b0, dmac_err_i = 1'b0;
    int               pass_cnt = 0, total = 0;

`ifdef DMA_CSR_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    dma_csr_tl_if #(.TL_AW(TL_AW)) csr_if ();

    dma_csr_tl #(.TL_AW(TL_AW)) dut (
        .dmac_clock_i          (dmac_clock_i),
        .dmac_reset_ni         (dmac_reset_ni),
        .csr                   (csr_if),
        .dmac_tx_o             (dmac_tx_o),
        .dmac_source_address_o (dmac_source_address_o),
        .dmac_dest_address_o   (dmac_dest_address_o),
        .dmac_bytes_tx_o       (dmac_bytes_tx_o),
        .dmac_stationary_rd_o  (dmac_stationary_rd_o),
        .dmac_stationary_wr_o  (dmac_stationary_wr_o),
        .dmac_busy_i           (dmac_busy_i),
        .dmac_done_i           (dmac_done_i),
        .dmac_err_i            (dmac_err_i),
        .dmac_irq_o            (dmac_irq_o)
    );

    always #5 dmac_clock_i = ~dmac_clock_i;

    // One request with d_ready=1; returns the D beat seen just after the firing edge.
    task automatic tl(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] mask, input logic [3:0] size,
                      output logic [31:0] rd, output logic den, output logic [2:0] dop);
        int n = 0;
        @(negedge dmac_clock_i);
        csr_if.csr_a_opcode = op;   csr_if.csr_a_address = addr;
        csr_if.csr_a_data   = data; csr_if.csr_a_mask    = mask;
        csr_if.csr_a_size   = size; csr_if.csr_a_valid   = 1'b1;
        csr_if.csr_d_ready  = 1'b1;
        while (!csr_if.csr_a_ready && n < 20) begin @(negedge dmac_clock_i); n++; end
        total++;
        if (n >= 20) $display("FAIL a_ready_timeout addr=%h got ready=0 want 1", addr);
        else pass_cnt++;
        @(posedge dmac_clock_i); #1;
        csr_if.csr_a_valid = 1'b0;
        rd = csr_if.csr_d_data; den = csr_if.csr_d_denied; dop = csr_if.csr_d_opcode;
        total++;
        if (csr_if.csr_d_valid !== 1'b1) $display("FAIL d_valid addr=%h got %b want 1", addr, csr_if.csr_d_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic den; logic [2:0] dop;
        #1;
        total++;
        if ({csr_if.csr_a_ready, csr_if.csr_d_valid, dmac_tx_o, dmac_irq_o} !== 4'b0)
            $display("FAIL reset_outs got %b want 0000",
                     {csr_if.csr_a_ready, csr_if.csr_d_valid, dmac_tx_o, dmac_irq_o});
        else pass_cnt++;
        repeat (2) @(negedge dmac_clock_i);
        dmac_reset_ni = 1'b1;
        tl(3'd4, 32'h08, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if ({den, rd} !== 33'd0) $display("FAIL reset_src got %h den=%b want 0", rd, den);
        else pass_cnt++;
    endtask

    task automatic test_rw();
        logic [31:0] rd; logic den; logic [2:0] dop;
        logic [31:0] addr [3] = '{32'h08, 32'h0C, 32'h10};
        logic [31:0] val  [3] = '{32'h1000, 32'h2000, 32'h40};
        for (int i = 0; i < 3; i++) begin
            tl(3'd0, addr[i], val[i], 4'hF, 4'd2, rd, den, dop);
            total++;
            if ({den, dop, rd} !== {1'b0, 3'd0, 32'd0})
                $display("FAIL put_ack a=%h got den=%b op=%0d d=%h want 0/0/0", addr[i], den, dop, rd);
            else pass_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            tl(3'd4, addr[i], 0, 4'hF, 4'd2, rd, den, dop);
            total++;
            if ({den, dop, rd} !== {1'b0, 3'd1, val[i]})
                $display("FAIL get_rb a=%h got den=%b op=%0d d=%h want 0/1/%h", addr[i], den, dop, rd, val[i]);
            else pass_cnt++;
        end
        tl(3'd1, 32'h12, 32'h0000_CD00, 4'b0010, 4'd2, rd, den, dop);
        total++;
        if ({dmac_source_address_o, dmac_dest_address_o, dmac_bytes_tx_o} !== {32'h1000, 32'h2000, 32'hCD40})
            $display("FAIL core_addrs got %h %h %h want 1000 2000 cd40",
                     dmac_source_address_o, dmac_dest_address_o, dmac_bytes_tx_o);
        else pass_cnt++;
    endtask

    task automatic test_start();
        logic [31:0] rd; logic den; logic [2:0] dop;
        tl(3'd0, 32'h00, 32'h7, 4'hF, 4'd2, rd, den, dop);
        total++;
        if ({dmac_tx_o, dmac_stationary_rd_o, dmac_stationary_wr_o} !== 3'b111)
            $display("FAIL start_pulse got tx/rd/wr=%b want 111",
                     {dmac_tx_o, dmac_stationary_rd_o, dmac_stationary_wr_o});
        else pass_cnt++;
        @(posedge dmac_clock_i); #1;
        total++;
        if (dmac_tx_o !== 1'b0) $display("FAIL start_one_cycle got tx=%b want 0", dmac_tx_o);
        else pass_cnt++;
        tl(3'd4, 32'h00, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (rd !== 32'h6) $display("FAIL ctrl_rb got %h want 6", rd);
        else pass_cnt++;
    endtask

    task automatic test_busy();
        logic [31:0] rd; logic den; logic [2:0] dop;
        @(negedge dmac_clock_i); dmac_busy_i = 1'b1;
        tl(3'd4, 32'h04, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (rd !== 32'h1) $display("FAIL status_busy got %h want 1", rd);
        else pass_cnt++;
        tl(3'd0, 32'h08, 32'h5555, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (den !== 1'b1) $display("FAIL busy_put_denied got %b want 1", den);
        else pass_cnt++;
        tl(3'd4, 32'h08, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (rd !== 32'h1000) $display("FAIL busy_src_kept got %h want 1000", rd);
        else pass_cnt++;
        repeat (10) @(negedge dmac_clock_i);
        dmac_busy_i = 1'b0;
        repeat (3) @(negedge dmac_clock_i);
        tl(3'd4, 32'h04, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (rd !== 32'h2) $display("FAIL status_done got %h want 2", rd);
        else pass_cnt++;
        tl(3'd0, 32'h04, 32'h2, 4'hF, 4'd2, rd, den, dop);
        tl(3'd4, 32'h04, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (rd !== 32'h0) $display("FAIL status_w1c got %h want 0", rd);
        else pass_cnt++;
    endtask

    task automatic test_denied();
        logic [31:0] rd; logic den; logic [2:0] dop;
        tl(3'd4, 32'h18, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if ({den, rd} !== {1'b1, 32'd0}) $display("FAIL deny_unmapped got den=%b d=%h want 1/0", den, rd);
        else pass_cnt++;
        tl(3'd4, 32'h08, 0, 4'hF, 4'd3, rd, den, dop);
        total++;
        if ({den, rd} !== {1'b1, 32'd0}) $display("FAIL deny_size3 got den=%b d=%h want 1/0", den, rd);
        else pass_cnt++;
        tl(3'd2, 32'h08, 32'h1, 4'hF, 4'd2, rd, den, dop);
        tl(3'd4, 32'h08, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if ({den, rd} !== {1'b0, 32'h1000}) $display("FAIL deny_opcode_nochg got den=%b d=%h want 0/1000", den, rd);
        else pass_cnt++;
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic den; logic [2:0] dop;
        tl(3'd0, 32'h00, 32'h9, 4'hF, 4'd2, rd, den, dop);
        tl(3'd4, 32'h04, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (rd !== 32'h0) $display("FAIL no_spurious_done got %h want 0", rd);
        else pass_cnt++;
        tl(3'd4, 32'h00, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (rd !== (IRQ_BUILD ? 32'h8 : 32'h0)) $display("FAIL ctrl_irq_en got %h want %h", rd, IRQ_BUILD ? 32'h8 : 32'h0);
        else pass_cnt++;
        @(negedge dmac_clock_i); dmac_busy_i = 1'b1; dmac_err_i = 1'b1;
        repeat (4) @(negedge dmac_clock_i);
        dmac_busy_i = 1'b0;
        repeat (2) @(negedge dmac_clock_i);
        dmac_err_i = 1'b0;
        @(negedge dmac_clock_i);
        total++;
        if (dmac_irq_o !== IRQ_BUILD) $display("FAIL irq_set got %b want %b", dmac_irq_o, IRQ_BUILD);
        else pass_cnt++;
        tl(3'd4, 32'h04, 0, 4'hF, 4'd2, rd, den, dop);
        total++;
        if (rd !== 32'h6) $display("FAIL status_err got %h want 6", rd);
        else pass_cnt++;
        tl(3'd0, 32'h04, 32'h6, 4'b0001, 4'd2, rd, den, dop);
        repeat (2) @(negedge dmac_clock_i);
        total++;
        if (dmac_irq_o !== 1'b0) $display("FAIL irq_clear got %b want 0", dmac_irq_o);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        @(negedge dmac_clock_i);
        csr_if.csr_a_opcode = 3'd4; csr_if.csr_a_address = 32'h08;
        csr_if.csr_a_size = 4'd2;   csr_if.csr_a_valid = 1'b1;
        csr_if.csr_d_ready = 1'b0;
        @(posedge dmac_clock_i); #1;
        csr_if.csr_a_valid = 1'b0;
        d0 = csr_if.csr_d_data;
        total++;
        if (d0 !== 32'h1000) $display("FAIL bp_data got %h want 1000", d0);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge dmac_clock_i);
            total++;
            if ({csr_if.csr_d_valid, csr_if.csr_d_data, csr_if.csr_a_ready} !== {1'b1, d0, 1'b0})
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h ar=%b want 1/%h/0", i,
                         csr_if.csr_d_valid, csr_if.csr_d_data, csr_if.csr_a_ready, d0);
            else pass_cnt++;
        end
        csr_if.csr_d_ready = 1'b1;
        @(negedge dmac_clock_i);
        total++;
        if (csr_if.csr_d_valid !== 1'b0) $display("FAIL bp_release got %b want 0", csr_if.csr_d_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        @(negedge dmac_clock_i);
        csr_if.csr_a_opcode = 3'd4; csr_if.csr_a_address = 32'h0C;
        csr_if.csr_a_size = 4'd2;   csr_if.csr_a_valid = 1'b1; csr_if.csr_d_ready = 1'b1;
        @(posedge dmac_clock_i); #1;
        csr_if.csr_a_address = 32'h10;
        total++;
        if ({csr_if.csr_d_data, csr_if.csr_a_ready} !== {32'h2000, 1'b1})
            $display("FAIL b2b_first got d=%h ar=%b want 2000/1", csr_if.csr_d_data, csr_if.csr_a_ready);
        else pass_cnt++;
        @(posedge dmac_clock_i); #1;
        csr_if.csr_a_valid = 1'b0;
        total++;
        if ({csr_if.csr_d_valid, csr_if.csr_d_data} !== {1'b1, 32'hCD40})
            $display("FAIL b2b_second got v=%b d=%h want 1/cd40", csr_if.csr_d_valid, csr_if.csr_d_data);
        else pass_cnt++;
    endtask

    initial begin
        csr_if.csr_a_opcode = '0; csr_if.csr_a_param = '0; csr_if.csr_a_size = '0;
        csr_if.csr_a_address = '0; csr_if.csr_a_mask = '0; csr_if.csr_a_data = '0;
        csr_if.csr_a_corrupt = 1'b0; csr_if.csr_a_valid = 1'b0; csr_if.csr_d_ready = 1'b1;
        test_reset();
        test_rw();
        test_start();
        test_busy();
        test_denied();
        test_irq();
        test_backpressure();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/dma_csr_tl.md
DMA_CSR_TL -- requirements
Module: dma_csr_tl

Interface
REQ-001 SHALL have parameter TL_AW, default 32: address width of the CSR port and of the programmed addresses.
REQ-002 SHALL have port dmac_clock_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port dmac_reset_ni, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have TileLink-UL A-channel inputs csr_a_opcode[2:0], csr_a_param[2:0], csr_a_size[3:0], csr_a_address[TL_AW-1:0], csr_a_mask[3:0], csr_a_data[31:0], csr_a_corrupt and csr_a_valid, plus output csr_a_ready.
REQ-005 SHALL have D-channel outputs csr_d_opcode[2:0], csr_d_param[1:0], csr_d_size[3:0], csr_d_denied, csr_d_data[31:0], csr_d_corrupt and csr_d_valid, plus input csr_d_ready.
REQ-006 SHALL drive DMA core command outputs: dmac_tx_o (1), dmac_source_address_o (TL_AW), dmac_dest_address_o (TL_AW), dmac_bytes_tx_o (TL_AW), dmac_stationary_rd_o (1) and dmac_stationary_wr_o (1).
REQ-007 SHALL take DMA core status inputs dmac_busy_i, dmac_done_i and dmac_err_i (1 bit each).
REQ-008 SHALL have output dmac_irq_o (1): level interrupt.

Function
REQ-009 SHALL decode the register map on csr_a_address[4:2]:
- 0x00 CTRL: b0 START (write-only, reads 0), b1 STAT_RD, b2 STAT_WR, b3 IRQ_EN.
- 0x04 STATUS: b0 BUSY (read-only), b1 DONE (W1C), b2 ERR (W1C).
- 0x08 SRC; 0x0C DST; 0x10 LEN (all read/write).
- Offsets 0x14-0x1C are unmapped; csr_a_address[1:0] is ignored.
REQ-010 SHALL accept Get (4), PutFullData (0) and PutPartialData (1); any other opcode, csr_a_size>2 or an unmapped offset SHALL get a response with csr_d_denied=1 and no state change.
REQ-011 SHALL assert csr_a_ready when no response is pending, or when the pending response is being accepted in the same cycle (csr_d_valid & csr_d_ready).
REQ-012 SHALL present the response one cycle after A fires: registered csr_d_valid, held stable until csr_d_ready.
- Opcode is AccessAckData (1) for Get and AccessAck (0) for Put.
- csr_d_size echoes csr_a_size; param=0 and corrupt=0.
REQ-013 SHALL return read data captured at A-fire; csr_d_data SHALL be 0 for writes and for denied accesses.
REQ-014 SHALL apply writes per byte lane via csr_a_mask for both Put opcodes.
REQ-015 SHALL treat writes to CTRL, SRC, DST or LEN while dmac_busy_i=1 as denied (csr_d_denied=1), with no update and no START.
REQ-016 SHALL pulse dmac_tx_o high for exactly one cycle, the cycle after an accepted CTRL write with byte 0 enabled and b0=1 while idle; the same write SHALL clear DONE and ERR.
REQ-017 SHALL drive dmac_*_address_o, dmac_bytes_tx_o and dmac_stationary_*_o continuously from SRC, DST, LEN, STAT_RD and STAT_WR.
REQ-018 SHALL NOT block START when LEN=0; the core completes immediately.
REQ-019 SHALL detect completion as a 1->0 transition of registered dmac_busy_i.
- On completion, DONE<=1 and ERR<=dmac_err_i.
- If a W1C and a completion occur in the same cycle, the set wins.
REQ-020 SHALL make a START pulse while dmac_busy_i is still 0 from the previous transfer (core latency of 1 cycle) not produce a spurious completion; completion requires an observed busy=1.

Reset
REQ-021 SHALL, while dmac_reset_ni=0, asynchronously clear all registers, dmac_tx_o, csr_d_valid, csr_d_* and dmac_irq_o.
REQ-022 SHALL hold csr_a_ready=0 during reset; a pending response SHALL be dropped.

Configuration
REQ-023 SHALL compile interrupt support under macro DMA_CSR_IRQ_EN.
- With DMA_CSR_IRQ_EN: dmac_irq_o = IRQ_EN & (DONE | ERR), registered.
- Without DMA_CSR_IRQ_EN: dmac_irq_o is tied 0, CTRL.b3 reads 0 and writes to it are ignored.

Verification
REQ-024 SHALL cover: Put SRC=0x1000, DST=0x2000, LEN=0x40 then Get each -> AccessAckData returns the same values with denied=0.
REQ-025 SHALL cover: Put CTRL=0x7 while idle -> dmac_tx_o high for 1 cycle; stationary_rd=1, stationary_wr=1.
REQ-026 SHALL cover: busy held 10 cycles then dropped with err=0 -> STATUS reads 0x2; writing 0x2 to STATUS -> STATUS reads 0x0.
REQ-027 SHALL cover: Put SRC while busy=1 -> denied=1 and SRC unchanged.
REQ-028 SHALL cover: Get at 0x18 and Get with size=3 -> denied=1 and data=0.
REQ-029 SHALL cover: with DMA_CSR_IRQ_EN, IRQ_EN=1 and completion with err=1 -> dmac_irq_o=1 and STATUS=0x6; W1C 0x6 -> irq drops to 0; csr_d_ready held low 5 cycles -> D output stable and csr_a_ready=0.
